// File: rtl/master_out_port_pkg.sv
// rtl/master_out_port_pkg.sv - shared system-bus widths and request-channel state encoding
package master_out_port_pkg;

    localparam int BUS_ADDR_W  = 12;
    localparam int BUS_DATA_W  = 8;
    localparam int BUS_BURST_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } bus_state_t;

    // Wait counter must hold TIMEOUT; a disabled timeout still needs one bit.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/master_out_port_if.sv
// rtl/master_out_port_if.sv - core request and serial request-channel signals of the master out port
interface master_out_port_if #(
    parameter int ADDR_W = master_out_port_pkg::BUS_ADDR_W,
    parameter int DATA_W = master_out_port_pkg::BUS_DATA_W
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              slave_ready;
    logic              master_valid;
    logic              read_en;
    logic              write_en;
    logic              tx_address;
    logic              tx_data;
    logic              tx_done;
    logic              tx_error;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, slave_ready,
        output req_ready, master_valid, read_en, write_en,
               tx_address, tx_data, tx_done, tx_error
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, slave_ready,
        input  req_ready, master_valid, read_en, write_en,
               tx_address, tx_data, tx_done, tx_error
    );
endinterface

// File: rtl/master_out_port_piso_shifter.sv
// rtl/master_out_port_piso_shifter.sv - parallel-load LSB-first shift register
module master_out_port_piso_shifter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_shift,
    output logic         o_bit
);
    logic [W-1:0] r_sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {1'b0, r_sr[W-1:1]};
        end
    end

    assign o_bit = r_sr[0];
endmodule

// File: rtl/master_out_port.sv
// rtl/master_out_port.sv - bit-serial request transmitter with valid/ready handshake toward the slave
module master_out_port
    import master_out_port_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 0
) (
    input logic               clk,
    input logic               reset,
    master_out_port_if.master bus
);
    localparam int WAIT_W = wait_cnt_width(TIMEOUT);

    bus_state_t        r_state;
    bus_state_t        w_next;
    logic              r_write;
    logic [3:0]        r_bit_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_tx_error;
    logic              w_accept;
    logic              w_handshake;
    logic              w_timeout;
    logic              w_shift;
    logic              w_addr_bit;
    logic              w_data_bit;
    logic [DATA_W-1:0] w_wdata_load;

    // Reads load zero so the data line stays quiet regardless of req_wdata.
    assign w_wdata_load = bus.req_write ? bus.req_wdata : '0;

    master_out_port_piso_shifter #(.W(ADDR_W)) u_addr_sr (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_data  (bus.req_addr),
        .i_shift (w_shift),
        .o_bit   (w_addr_bit)
    );

    master_out_port_piso_shifter #(.W(DATA_W)) u_data_sr (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_data  (w_wdata_load),
        .i_shift (w_shift),
        .o_bit   (w_data_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_accept         = 1'b0;
        w_handshake      = 1'b0;
        w_timeout        = 1'b0;
        w_shift          = 1'b0;
        bus.req_ready    = 1'b0;
        bus.master_valid = 1'b0;
        bus.read_en      = 1'b0;
        bus.write_en     = 1'b0;
        bus.tx_address   = 1'b0;
        bus.tx_data      = 1'b0;
        bus.tx_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.master_valid = 1'b1;
                bus.read_en      = ~r_write;
                bus.write_en     = r_write;
                bus.tx_address   = w_addr_bit;
                bus.tx_data      = r_write & w_data_bit;
                // Bit 0 is captured by the slave on the handshake edge itself.
                if (bus.slave_ready) begin
                    w_handshake = 1'b1;
                    w_shift     = 1'b1;
                    w_next      = ST_SHIFT;
                end else if ((TIMEOUT != 0) && (int'(r_wait_cnt) == TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bus.read_en    = ~r_write;
                bus.write_en   = r_write;
                bus.tx_address = w_addr_bit;
                bus.tx_data    = r_write & (int'(r_bit_cnt) < DATA_W) & w_data_bit;
                w_shift        = 1'b1;
                if (int'(r_bit_cnt) == ADDR_W - 1) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.tx_done = 1'b1;
                w_next      = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_tx_error <= 1'b0;
        end else begin
            r_tx_error <= w_timeout;
            if (w_accept) begin
                r_write    <= bus.req_write;
                r_wait_cnt <= '0;
            end else if ((r_state == ST_REQ) && !w_handshake) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_handshake) begin
                r_bit_cnt <= 4'd1;
            end else if (r_state == ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    assign bus.tx_error = r_tx_error;
endmodule

// File: tb/tb_master_out_port.sv
// tb/tb_master_out_port.sv - scoreboard bench for the master out port serial transmitter
module tb_master_out_port;
    import master_out_port_pkg::*;

    typedef struct packed {
        logic        w;
        logic [11:0] a;
        logic [7:0]  d;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    master_out_port_if bus0 ();
    master_out_port_if bus1 ();

    master_out_port #(.TIMEOUT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    master_out_port #(.TIMEOUT(4)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    wire [7:0] out0 = {bus0.req_ready, bus0.master_valid, bus0.read_en, bus0.write_en,
                       bus0.tx_address, bus0.tx_data, bus0.tx_done, bus0.tx_error};
    wire [7:0] out1 = {bus1.req_ready, bus1.master_valid, bus1.read_en, bus1.write_en,
                       bus1.tx_address, bus1.tx_data, bus1.tx_done, bus1.tx_error};

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: busy for the serial window after a handshake, plus a 4-cycle gap after writes.
    logic sr0_en = 1'b0;
    int   sl_cnt = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) sl_cnt <= 0;
        else if (bus0.master_valid && bus0.slave_ready) sl_cnt <= bus0.write_en ? 15 : 11;
        else if (sl_cnt != 0) sl_cnt <= sl_cnt - 1;
    end
    assign bus0.slave_ready = sr0_en && (sl_cnt == 0);

    logic        busy       = 1'b0;
    int          bit_idx    = 0;
    int          n_done     = 0;
    logic [11:0] cap_a      = '0;
    logic [11:0] cap_d      = '0;
    logic [1:0]  cap_en     = '0;
    logic        win_bad    = 1'b0;
    logic        err0_seen  = 1'b0;
    logic        stray_done = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            busy    = 1'b0;
            bit_idx = 0;
        end else begin
            if (bus0.tx_error) err0_seen = 1'b1;
            if (bus0.tx_done && !(busy && bit_idx == 12)) stray_done = 1'b1;
            if (busy && bit_idx < 12) begin
                cap_a[bit_idx] = bus0.tx_address;
                cap_d[bit_idx] = bus0.tx_data;
                if (bus0.master_valid || ({bus0.write_en, bus0.read_en} != cap_en)) win_bad = 1'b1;
                bit_idx++;
            end else if (busy) begin
                exp_t e;
                check_eq("tx_done_after_12", bus0.tx_done, 1);
                check_eq("en_clear_in_done", {bus0.write_en, bus0.read_en}, 0);
                check_eq("window_clean", win_bad, 0);
                check_eq("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("dir", cap_en, e.w ? 2'b10 : 2'b01);
                    check_eq("addr", cap_a, e.a);
                    check_eq("data", cap_d, {4'b0, e.d});
                end
                busy = 1'b0;
                n_done++;
            end else if (bus0.master_valid && bus0.slave_ready) begin
                busy      = 1'b1;
                cap_a[0]  = bus0.tx_address;
                cap_d[0]  = bus0.tx_data;
                cap_en    = {bus0.write_en, bus0.read_en};
                win_bad   = 1'b0;
                bit_idx   = 1;
            end
        end
    end

    task automatic send0(input logic w, input logic [11:0] a, input logic [7:0] d);
        exp_t e;
        int   n = 0;
        while (!bus0.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("req_ready_wait", bus0.req_ready, 1);
        bus0.req_valid = 1'b1;
        bus0.req_write = w;
        bus0.req_addr  = a;
        bus0.req_wdata = d;
        e.w = w;
        e.a = a;
        e.d = w ? d : 8'h00;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        check_eq("req_ready_drop", bus0.req_ready, 0);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (n_done < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("done_count", n_done, target);
    endtask

    initial begin
        int n;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus1.slave_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs0", out0, 8'h80);
        check_eq("reset_outs1", out1, 8'h80);
        reset = 1'b0;
        @(posedge clk); #1;

        // Timeout: slave never ready
        bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 12'h155; bus1.req_wdata = 8'h0F;
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        check_eq("to_req_state", {bus1.req_ready, bus1.master_valid, bus1.tx_address}, 3'b011);
        repeat (3) @(posedge clk);
        #1;
        check_eq("to_still_waiting", {bus1.master_valid, bus1.tx_error}, 2'b10);
        @(posedge clk); #1;
        check_eq("to_error_pulse", {bus1.tx_error, bus1.master_valid, bus1.req_ready, bus1.write_en}, 4'b1010);
        @(posedge clk); #1;
        check_eq("to_error_one_cycle", {bus1.tx_error, bus1.req_ready}, 2'b01);

        sr0_en = 1'b1;
        send0(1'b1, 12'hA5C, 8'h3E);
        wait_done(1);
        send0(1'b0, 12'h001, 8'hFF);
        wait_done(2);

        // Slave holds ready low for 5 REQ cycles, handshake on the 6th
        sr0_en = 1'b0;
        send0(1'b1, 12'h3C7, 8'h81);
        check_eq("hold_valid_bit0", {bus0.master_valid, bus0.tx_address}, 2'b11);
        repeat (4) @(posedge clk);
        #1;
        check_eq("hold_after_5", {bus0.master_valid, bus0.tx_address, bus0.tx_error}, 3'b110);
        @(posedge clk); #1;
        sr0_en = 1'b1;
        wait_done(3);

        send0(1'b1, 12'h010, 8'h5A);
        send0(1'b1, 12'h020, 8'hC3);
        wait_done(5);

        // Reset in the middle of serial bit 5
        send0(1'b1, 12'h7FF, 8'hFF);
        n = 0;
        while (!(busy && bit_idx == 5) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("reached_bit5", busy && bit_idx == 5, 1);
        reset = 1'b1;
        #1;
        check_eq("async_reset_outs", out0, 8'h80);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        send0(1'b1, 12'h123, 8'h45);
        wait_done(6);

        repeat (20) @(posedge clk);
        #1;
        check_eq("no_tx_error_t0", err0_seen, 0);
        check_eq("no_stray_done", stray_done, 0);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
